// File: rtl/fractal_engine.sv
// Escape-time fractal engine: iterates z <= z^2 + c (Mandelbrot or Julia) for
// one pixel at a time and reports the iteration count, escape flag and tag.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   enable                 0 freezes every register and blocks both handshakes
//   in_valid/in_ready      pixel request handshake (ready only while idle)
//   pixel_x/pixel_y/in_tag pixel coordinates and opaque tag
//   julia_mode, center_*, julia_c*, zoom, max_iter   view settings, sampled at accept
//   out_valid/out_ready    result handshake; result held under backpressure
//   iter_count/escaped/out_tag                       result payload
module fractal_engine #(
  parameter int unsigned COORD_WIDTH = 16,
  parameter int unsigned FRAC_BITS   = 12,
  parameter int unsigned ITER_WIDTH  = 8,
  parameter int unsigned PIX_WIDTH   = 10,
  parameter int unsigned TAG_WIDTH   = 4,
  parameter int unsigned X_HALF      = 320,
  parameter int unsigned Y_HALF      = 240,
  parameter int unsigned STEP_BASE   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PIX_WIDTH-1:0]          pixel_x,
  input  logic [PIX_WIDTH-1:0]          pixel_y,
  input  logic [TAG_WIDTH-1:0]          in_tag,
  input  logic                          julia_mode,
  input  logic signed [COORD_WIDTH-1:0] center_x,
  input  logic signed [COORD_WIDTH-1:0] center_y,
  input  logic signed [COORD_WIDTH-1:0] julia_cr,
  input  logic signed [COORD_WIDTH-1:0] julia_ci,
  input  logic [4:0]                    zoom,
  input  logic [ITER_WIDTH-1:0]         max_iter,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ITER_WIDTH-1:0]         iter_count,
  output logic                          escaped,
  output logic [TAG_WIDTH-1:0]          out_tag
);

  localparam int unsigned CW  = COORD_WIDTH;
  localparam int unsigned PW2 = 2 * COORD_WIDTH;
  localparam int unsigned OW  = PIX_WIDTH + 1;
  // Wide working width: holds products, their sums and the pixel mapping without overflow.
  localparam int unsigned WW  = 2 * COORD_WIDTH + PIX_WIDTH + 8;

  localparam logic signed [WW-1:0] SMAX   = {{(WW-CW+1){1'b0}}, {(CW-1){1'b1}}};
  localparam logic signed [WW-1:0] SMIN   = {{(WW-CW+1){1'b1}}, {(CW-1){1'b0}}};
  localparam logic signed [WW-1:0] ESC_TH = WW'(4 << FRAC_BITS);
  localparam logic signed [WW-1:0] STEP_W = WW'(STEP_BASE);
  localparam logic signed [OW-1:0] XH     = OW'(X_HALF);
  localparam logic signed [OW-1:0] YH     = OW'(Y_HALF);

  typedef enum logic [2:0] {IDLE, LOAD, MUL, UPD, DONE} state_e;

  state_e state_q, state_d;

  logic [PIX_WIDTH-1:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [TAG_WIDTH-1:0]   tag_q, tag_d;
  logic                   julia_q, julia_d;
  logic signed [CW-1:0]   cx_q, cx_d, cy_q, cy_d, jcr_q, jcr_d, jci_q, jci_d;
  logic [4:0]             zoom_q, zoom_d;
  logic [ITER_WIDTH-1:0]  max_q, max_d, iter_q, iter_d;
  logic signed [CW-1:0]   zr_q, zr_d, zi_q, zi_d, cr_q, cr_d, ci_q, ci_d;
  logic signed [PW2-1:0]  zr2_q, zr2_d, zi2_q, zi2_d, zrzi_q, zrzi_d;
  logic                   out_valid_q, out_valid_d, escaped_q, escaped_d;
  logic [ITER_WIDTH-1:0]  iter_count_q, iter_count_d;
  logic [TAG_WIDTH-1:0]   out_tag_q, out_tag_d;

  logic [4:0]             shamt;
  logic signed [OW-1:0]   off_x, off_y;
  logic signed [CW-1:0]   map_x, map_y, nzr, nzi;
  logic signed [WW-1:0]   mag;

  // Clamp a wide signed value into the coordinate range.
  function automatic logic signed [CW-1:0] sat(input logic signed [WW-1:0] v);
    if (v > SMAX)      return SMAX[CW-1:0];
    else if (v < SMIN) return SMIN[CW-1:0];
    else               return CW'(v);
  endfunction

  // Pixel-to-plane mapping, magnitude and next z from the registered operands.
  always_comb begin
    shamt = (zoom_q > 5'(CW-1)) ? 5'(CW-1) : zoom_q;
    off_x = $signed({1'b0, pix_x_q}) - XH;
    off_y = $signed({1'b0, pix_y_q}) - YH;
    map_x = sat(WW'(cx_q) + ((WW'(off_x) * STEP_W) >>> shamt));
    map_y = sat(WW'(cy_q) + ((WW'(off_y) * STEP_W) >>> shamt));
    mag   = (WW'(zr2_q) + WW'(zi2_q)) >>> FRAC_BITS;
    nzr   = sat(((WW'(zr2_q) - WW'(zi2_q)) >>> FRAC_BITS) + WW'(cr_q));
    nzi   = sat(((WW'(zrzi_q) <<< 1) >>> FRAC_BITS) + WW'(ci_q));
  end

  // Next-state and datapath control.
  always_comb begin
    state_d      = state_q;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    tag_d        = tag_q;
    julia_d      = julia_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    jcr_d        = jcr_q;
    jci_d        = jci_q;
    zoom_d       = zoom_q;
    max_d        = max_q;
    iter_d       = iter_q;
    zr_d         = zr_q;
    zi_d         = zi_q;
    cr_d         = cr_q;
    ci_d         = ci_q;
    zr2_d        = zr2_q;
    zi2_d        = zi2_q;
    zrzi_d       = zrzi_q;
    out_valid_d  = out_valid_q;
    escaped_d    = escaped_q;
    iter_count_d = iter_count_q;
    out_tag_d    = out_tag_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pix_x_d = pixel_x;
          pix_y_d = pixel_y;
          tag_d   = in_tag;
          julia_d = julia_mode;
          cx_d    = center_x;
          cy_d    = center_y;
          jcr_d   = julia_cr;
          jci_d   = julia_ci;
          zoom_d  = zoom;
          max_d   = max_iter;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (julia_q) begin
          zr_d = map_x;
          zi_d = map_y;
          cr_d = jcr_q;
          ci_d = jci_q;
        end else begin
          zr_d = '0;
          zi_d = '0;
          cr_d = map_x;
          ci_d = map_y;
        end
        iter_d  = '0;
        state_d = MUL;
      end
      MUL: begin
        zr2_d   = PW2'(zr_q) * PW2'(zr_q);
        zi2_d   = PW2'(zi_q) * PW2'(zi_q);
        zrzi_d  = PW2'(zr_q) * PW2'(zi_q);
        state_d = UPD;
      end
      UPD: begin
        // Limit check precedes the increment, so the counter never wraps.
        if (mag > ESC_TH || iter_q == max_q) begin
          escaped_d    = (mag > ESC_TH);
          iter_count_d = iter_q;
          out_tag_d    = tag_q;
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end else begin
          zr_d    = nzr;
          zi_d    = nzi;
          iter_d  = iter_q + ITER_WIDTH'(1);
          state_d = MUL;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; enable low freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      tag_q        <= '0;
      julia_q      <= 1'b0;
      cx_q         <= '0;
      cy_q         <= '0;
      jcr_q        <= '0;
      jci_q        <= '0;
      zoom_q       <= '0;
      max_q        <= '0;
      iter_q       <= '0;
      zr_q         <= '0;
      zi_q         <= '0;
      cr_q         <= '0;
      ci_q         <= '0;
      zr2_q        <= '0;
      zi2_q        <= '0;
      zrzi_q       <= '0;
      out_valid_q  <= 1'b0;
      escaped_q    <= 1'b0;
      iter_count_q <= '0;
      out_tag_q    <= '0;
    end else if (enable) begin
      state_q      <= state_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      tag_q        <= tag_d;
      julia_q      <= julia_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      jcr_q        <= jcr_d;
      jci_q        <= jci_d;
      zoom_q       <= zoom_d;
      max_q        <= max_d;
      iter_q       <= iter_d;
      zr_q         <= zr_d;
      zi_q         <= zi_d;
      cr_q         <= cr_d;
      ci_q         <= ci_d;
      zr2_q        <= zr2_d;
      zi2_q        <= zi2_d;
      zrzi_q       <= zrzi_d;
      out_valid_q  <= out_valid_d;
      escaped_q    <= escaped_d;
      iter_count_q <= iter_count_d;
      out_tag_q    <= out_tag_d;
    end
  end

  // Ready is held low through reset and whenever the engine is frozen.
  assign in_ready   = rst_n && enable && (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign escaped    = escaped_q;
  assign iter_count = iter_count_q;
  assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_fractal_engine.sv
// Bench for fractal_engine: directed pixels with hand-computed results; a
// scoreboard queue holds expected results, a monitor checks each output handshake.
module tb_fractal_engine;

  logic        clk = 1'b0;
  logic        rst_n, enable, in_valid, in_ready, julia_mode;
  logic [9:0]  pixel_x, pixel_y;
  logic [3:0]  in_tag, out_tag;
  logic signed [15:0] center_x, center_y, julia_cr, julia_ci;
  logic [4:0]  zoom;
  logic [7:0]  max_iter, iter_count;
  logic        out_valid, out_ready, escaped;

  typedef struct {
    int iter;
    int esc;
    int tag;
    int lat;
    int acc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   rise_cyc = 0;
  logic prev_v = 1'b0;

  fractal_engine dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .in_tag(in_tag),
    .julia_mode(julia_mode), .center_x(center_x), .center_y(center_y),
    .julia_cr(julia_cr), .julia_ci(julia_ci), .zoom(zoom), .max_iter(max_iter),
    .out_valid(out_valid), .out_ready(out_ready),
    .iter_count(iter_count), .escaped(escaped), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: record the cycle out_valid rises, check each completed output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) rise_cyc = cyc;
      prev_v = out_valid;
      if (out_valid && out_ready && enable) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("iter_count", longint'(iter_count), e.iter);
          chk("escaped", longint'(escaped), e.esc);
          chk("out_tag", longint'(out_tag), e.tag);
          chk("latency", rise_cyc - e.acc, e.lat);
        end
      end
    end
  end

  // Offer one pixel, push its expected result at accept, then scramble inputs.
  task automatic send(input int px, input int py, input int tg, input int jm,
                      input int cxv, input int cyv, input int jr, input int ji,
                      input int zm, input int mi,
                      input int e_iter, input int e_esc, input int e_lat);
    bit got = 0;
    exp_t e;
    @(posedge clk); #1;
    pixel_x = 10'(px); pixel_y = 10'(py); in_tag = 4'(tg); julia_mode = 1'(jm);
    center_x = 16'(cxv); center_y = 16'(cyv); julia_cr = 16'(jr); julia_ci = 16'(ji);
    zoom = 5'(zm); max_iter = 8'(mi);
    in_valid = 1'b1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
    end else begin
      e.iter = e_iter; e.esc = e_esc; e.tag = tg; e.lat = e_lat; e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    pixel_x = 10'($urandom); pixel_y = 10'($urandom); in_tag = 4'($urandom);
    julia_mode = 1'($urandom); center_x = 16'($urandom); center_y = 16'($urandom);
    julia_cr = 16'($urandom); julia_ci = 16'($urandom);
    zoom = 5'($urandom); max_iter = 8'($urandom);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    pixel_x = '0; pixel_y = '0; in_tag = '0; julia_mode = 1'b0;
    center_x = '0; center_y = '0; julia_cr = '0; julia_ci = '0;
    zoom = '0; max_iter = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_iter_count", longint'(iter_count), 0);
    chk("rst_escaped", longint'(escaped), 0);
    chk("rst_out_tag", longint'(out_tag), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", longint'(in_ready), 1);

    // Centre point: c = 0 never escapes.
    send(320, 240, 5, 0, 0, 0, 0, 0, 0, 20, 20, 0, 44); wait_done();
    // Left edge: c = -2.5 escapes after one update.
    send(0, 240, 6, 0, 0, 0, 0, 0, 0, 20, 1, 1, 6); wait_done();
    // Julia, c = 0, z0 = 2.0: |z|^2 = 4.0 does not escape, then 16.0 does.
    send(576, 240, 7, 1, 0, 0, 0, 0, 0, 20, 1, 1, 6); wait_done();
    // Imaginary axis: c = -1.875i escapes at count 2.
    send(320, 0, 8, 0, 0, 0, 0, 0, 0, 20, 2, 1, 8); wait_done();
    // Zoom 2: c = -0.625 is inside the main cardioid.
    send(0, 240, 9, 0, 0, 0, 0, 0, 2, 10, 10, 0, 24); wait_done();
    // Zero limit: single check, count 0, no escape.
    send(0, 240, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4); wait_done();

    // Freeze for 3 cycles mid-compute: latency grows by exactly 3.
    send(0, 240, 11, 0, 0, 0, 0, 0, 0, 20, 1, 1, 9);
    @(posedge clk); #1 enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 enable = 1'b1;
    wait_done();

    // Backpressure: result held for 10 cycles, then a single handshake.
    out_ready = 1'b0;
    send(320, 0, 12, 0, 0, 0, 0, 0, 0, 20, 2, 1, 8);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("bp_valid_seen", longint'(out_valid), 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", longint'(out_valid), 1);
      chk("bp_hold_ready", longint'(in_ready), 0);
      chk("bp_hold_iter", longint'(iter_count), 2);
      chk("bp_hold_tag", longint'(out_tag), 12);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_after_ready", longint'(in_ready), 1);
    chk("bp_after_valid", longint'(out_valid), 0);
    chk("bp_sb_empty", sb.size(), 0);

    // Reset during MUL drops the pixel.
    send(320, 240, 13, 0, 0, 0, 0, 0, 0, 20, 20, 0, 44);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_in_ready", longint'(in_ready), 0);
    chk("midrst_iter_count", longint'(iter_count), 0);
    chk("midrst_out_tag", longint'(out_tag), 0);
    if (sb.size() > 0) void'(sb.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(0, 240, 3, 0, 0, 0, 0, 0, 0, 20, 1, 1, 6); wait_done();

    repeat (3) @(negedge clk);
    chk("end_out_valid", longint'(out_valid), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fractal_engine.md
Name: fractal_engine

Overview:
- Parametrised, handshaked escape-time engine: z(n+1) = z(n)^2 + c, in Mandelbrot or Julia mode.
- Sits between the pixel scan/scheduler and the colour mapper.
- Accepts one pixel per valid/ready transaction and returns iteration count, escape flag and a pass-through tag.
- Holds the result under output backpressure.

Parameters:
- COORD_WIDTH, 16, signed fixed-point width of c and z (two's complement).
- FRAC_BITS, 12, fractional bits of c and z.
- ITER_WIDTH, 8, width of the iteration counter and the max_iter input.
- PIX_WIDTH, 10, width of pixel_x and pixel_y.
- TAG_WIDTH, 4, width of the opaque tag carried from input to output.
- X_HALF, 320, pixel_x value that maps to center_x.
- Y_HALF, 240, pixel_y value that maps to center_y.
- STEP_BASE, 32, coordinate step per pixel at zoom 0, in LSBs (32 = 1/128 at FRAC_BITS = 12).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  0 = freeze all state and hold outputs
- in_valid  in  1  pixel request valid
- in_ready  out  1  engine can accept a pixel
- pixel_x  in  PIX_WIDTH  unsigned pixel column
- pixel_y  in  PIX_WIDTH  unsigned pixel row
- in_tag  in  TAG_WIDTH  opaque tag
- julia_mode  in  1  0 = Mandelbrot, 1 = Julia
- center_x  in  COORD_WIDTH  signed view centre, real
- center_y  in  COORD_WIDTH  signed view centre, imaginary
- julia_cr  in  COORD_WIDTH  signed Julia constant, real
- julia_ci  in  COORD_WIDTH  signed Julia constant, imaginary
- zoom  in  5  right-shift applied to the pixel step
- max_iter  in  ITER_WIDTH  iteration limit
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- iter_count  out  ITER_WIDTH  final iteration count
- escaped  out  1  1 = |z|^2 exceeded 4.0
- out_tag  out  TAG_WIDTH  tag of this result

Behaviour:
- Reset: state = IDLE; out_valid = 0; iter_count, escaped, out_tag, z, c and all product registers = 0; in_ready = 0 while rst_n is low.
- States and transitions:
  - IDLE: in_ready = enable. An accept is in_valid && in_ready. On accept, register pixel_x, pixel_y, in_tag and julia_mode, plus center_x/y, julia_cr/ci, zoom and max_iter. Go to LOAD.
  - LOAD: compute mapped = center + ((pix - HALF) * STEP_BASE) >>> min(zoom, COORD_WIDTH-1), per axis. Offset is signed, width PIX_WIDTH+1. Arithmetic shift; sum saturates to the COORD_WIDTH range.
    - Mandelbrot: c = mapped, z = 0.
    - Julia: z = mapped, c = julia constants.
    - Clear iter. Go to MUL.
  - MUL: register zr*zr, zi*zi and zr*zi at full 2*COORD_WIDTH width. Go to UPD.
  - UPD: mag = (zr2 + zi2) >>> FRAC_BITS, kept at full width with no truncation.
    - If mag > (4 << FRAC_BITS): go to DONE with escaped = 1.
    - Else if iter == max_iter: go to DONE with escaped = 0.
    - Else: zr = (zr2 - zi2) >>> FRAC_BITS + cr and zi = (zrzi <<< 1) >>> FRAC_BITS + ci, each saturated to the COORD_WIDTH range. iter increments. Go to MUL.
  - DONE: out_valid = 1. iter_count, escaped and out_tag stay stable until out_valid && out_ready. In the handshake cycle, go to IDLE.
- Latency: with accept in cycle T and final count n, out_valid first rises in cycle T+4+2n. The next accept can occur in the cycle after the output handshake. There is no overlap (in_ready = 0 outside IDLE).
- Counting: max_iter = 0 gives one check, then count 0. The iter counter never wraps, because the limit check precedes the increment.
- Sampling: inputs other than the handshake are sampled only at accept. Later changes do not affect the in-flight pixel.
- enable = 0:
  - No state, register or output changes.
  - in_ready = 0.
  - out_valid holds its value, but no output handshake completes.
- Async reset mid-operation: immediate return to the reset values. The in-flight pixel is dropped and no result is produced.

Test Plan:
- Centre point: center = 0, zoom = 0, max_iter = 20, Mandelbrot, pixel (320,240), tag 5, out_ready = 1. Required: iter_count = 20, escaped = 0, out_tag = 5, out_valid at T+44.
- Left edge: pixel (0,240), other settings as the centre-point case, so c = -2.5. Required: iter_count = 1, escaped = 1, out_valid at T+6.
- Julia mode: julia_c = 0, pixel (576,240), so z0 = 2.0. Required: |z0|^2 = 4.0 does not escape, then escape at iter_count = 1.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid. Required: outputs stable and in_ready = 0; a single handshake, then in_ready = 1 the next cycle.
- Zero limit and freeze: max_iter = 0 gives iter_count = 0 and escaped = 0. Toggling enable low mid-compute extends latency by exactly the number of low cycles.
- Reset mid-operation: assert rst_n low during MUL. Required: out_valid = 0 and in_ready = 0 immediately; after release, the next pixel completes normally.
